// File: rtl/bitmap_stream_loader_pkg.sv
// Shared types and helpers for the bitmap stream loader: FSM state encoding, lane count, log2.
// No logic of its own.
package bitmap_stream_loader_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_INIT,
        ST_FILL,
        ST_DRAIN,
        ST_GAP,
        ST_START,
        ST_WAIT_DONE
    } state_t;

    localparam int LANES = 128 / 32;

    function automatic int clog2(input int value);
        int result;
        int v;
        result = 0;
        v = value - 1;
        while (v > 0) begin
            result = result + 1;
            v = v >>> 1;
        end
        return result;
    endfunction

endpackage

// File: rtl/bitmap_lane_packer.sv
// Packs host words into one wide word; strobe 1 cycle after the lane-full or last accept.
// No backpressure: one word per cycle whenever wr is high.
module bitmap_lane_packer
    import bitmap_stream_loader_pkg::*;
#(
    parameter int WORD_WIDTH = 32,
    parameter int NUM_LANES  = LANES
) (
    input  logic                            clock,
    input  logic                            reset_n,
    input  logic                            clear,
    input  logic                            wr,
    input  logic                            last,
    input  logic [WORD_WIDTH-1:0]           data,
    output logic [NUM_LANES*WORD_WIDTH-1:0] packed_word,
    output logic                            packed_vld
);
    localparam int LANE_W = (NUM_LANES > 1) ? clog2(NUM_LANES) : 1;

    typedef logic [NUM_LANES-1:0][WORD_WIDTH-1:0] lanes_t;

    lanes_t            shadow;
    lanes_t            merged;
    lanes_t            out_q;
    logic [LANE_W-1:0] lane_cnt;
    logic              flush;

    // Lanes above the current one are forced to zero so a short final beat carries no stale data.
    always_comb begin
        merged = '0;
        for (int k = 0; k < NUM_LANES; k++) begin
            if (k < int'(lane_cnt)) begin
                merged[k] = shadow[k];
            end else if (k == int'(lane_cnt)) begin
                merged[k] = data;
            end
        end
    end

    assign flush = wr && (last || (lane_cnt == LANE_W'(NUM_LANES - 1)));

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            shadow     <= '0;
            lane_cnt   <= '0;
            out_q      <= '0;
            packed_vld <= 1'b0;
        end else begin
            packed_vld <= flush;
            if (clear || flush) begin
                shadow   <= '0;
                lane_cnt <= '0;
            end else if (wr) begin
                shadow   <= merged;
                lane_cnt <= lane_cnt + LANE_W'(1);
            end
            if (flush) begin
                out_q <= merged;
            end
        end
    end

    assign packed_word = out_q;

endmodule

// File: rtl/bitmap_stream_loader.sv
// Host word stream to controller bitmap-write feeder; start pulse 2 cycles after the last strobe.
// Host is backpressured (s_ready low) outside FILL/DRAIN; the controller side has no backpressure.
module bitmap_stream_loader
    import bitmap_stream_loader_pkg::*;
#(
    parameter int IN_SIZE_WIDTH        = 32,
    parameter int BITMAP_MEM_WIDTH     = 128,
    parameter int WORD_WIDTH           = 32,
    parameter int MAX_BITMAP_MEM_DEPTH = 2048
) (
    input  logic                        clock,
    input  logic                        reset_n,
    input  logic [WORD_WIDTH-1:0]       s_data,
    input  logic                        s_valid,
    input  logic                        s_last,
    input  logic [5:0]                  s_last_bits,
    output logic                        s_ready,
    input  logic                        ctrl_ready,
    input  logic                        done_signal,
    output logic                        init,
    output logic [BITMAP_MEM_WIDTH-1:0] in_bitmap,
    output logic                        in_bitmap_valid,
    output logic [IN_SIZE_WIDTH-1:0]    in_bitmap_size,
    output logic                        start_signal,
    output logic                        busy,
    output logic                        overflow
);
    localparam int NUM_LANES  = BITMAP_MEM_WIDTH / WORD_WIDTH;
    localparam int WORD_LIMIT = MAX_BITMAP_MEM_DEPTH * NUM_LANES;

    state_t      state;
    state_t      next_state;
    logic [14:0] word_cnt;
    logic        word_acc;
    logic        pack_wr;
    logic        ovf_set;
    logic        size_load;
    logic        start_pulse;
    logic [31:0] last_bits;
    logic [31:0] frame_bits;

    assign last_bits  = (s_last_bits == 6'd0 || int'(s_last_bits) > WORD_WIDTH)
                        ? 32'(WORD_WIDTH) : 32'(s_last_bits);
    // word_cnt still excludes the final word here, so this is 32*(words-1) + last_bits.
    assign frame_bits = 32'(word_cnt) * 32'(WORD_WIDTH) + last_bits;
    assign busy       = (state != ST_IDLE);

    always_comb begin
        next_state  = state;
        s_ready     = 1'b0;
        init        = 1'b0;
        word_acc    = 1'b0;
        pack_wr     = 1'b0;
        ovf_set     = 1'b0;
        size_load   = 1'b0;
        start_pulse = 1'b0;
        case (state)
            ST_IDLE: begin
                if (s_valid && ctrl_ready) next_state = ST_INIT;
            end
            ST_INIT: begin
                init       = 1'b1;
                next_state = ST_FILL;
            end
            ST_FILL: begin
                s_ready = 1'b1;
                if (s_valid) begin
                    word_acc = 1'b1;
                    if (int'(word_cnt) >= WORD_LIMIT) begin
                        ovf_set    = 1'b1;
                        next_state = s_last ? ST_IDLE : ST_DRAIN;
                    end else begin
                        pack_wr = 1'b1;
                        if (s_last) begin
                            size_load  = 1'b1;
                            next_state = ST_GAP;
                        end
                    end
                end
            end
            ST_DRAIN: begin
                s_ready = 1'b1;
                if (s_valid && s_last) next_state = ST_IDLE;
            end
            ST_GAP: begin
                next_state = ST_START;
            end
            ST_START: begin
                start_pulse = 1'b1;
                next_state  = ST_WAIT_DONE;
            end
            ST_WAIT_DONE: begin
                if (done_signal) next_state = ST_IDLE;
            end
            default: begin
                next_state = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state          <= ST_IDLE;
            word_cnt       <= '0;
            overflow       <= 1'b0;
            in_bitmap_size <= '0;
            start_signal   <= 1'b0;
        end else begin
            state        <= next_state;
            start_signal <= start_pulse;
            if (init) begin
                word_cnt       <= '0;
                overflow       <= 1'b0;
                in_bitmap_size <= '0;
            end else begin
                if (word_acc && word_cnt != '1) word_cnt <= word_cnt + 15'd1;
                if (ovf_set) overflow <= 1'b1;
                if (size_load) in_bitmap_size <= IN_SIZE_WIDTH'(frame_bits);
            end
        end
    end

    bitmap_lane_packer #(
        .WORD_WIDTH (WORD_WIDTH),
        .NUM_LANES  (NUM_LANES)
    ) u_packer (
        .clock       (clock),
        .reset_n     (reset_n),
        .clear       (init),
        .wr          (pack_wr),
        .last        (s_last),
        .data        (s_data),
        .packed_word (in_bitmap),
        .packed_vld  (in_bitmap_valid)
    );

endmodule

// File: tb/tb_bitmap_stream_loader.sv
// Scoreboard bench: driver pushes model-derived strobes/sizes, a negedge monitor pops and compares.
module tb_bitmap_stream_loader;
    localparam int MAXD = 2;

    logic         clock = 1'b0;
    logic         reset_n = 1'b0;
    logic [31:0]  s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_last = 1'b0;
    logic [5:0]   s_last_bits = '0;
    logic         s_ready;
    logic         ctrl_ready = 1'b0;
    logic         done_signal = 1'b0;
    logic         init;
    logic [127:0] in_bitmap;
    logic         in_bitmap_valid;
    logic [31:0]  in_bitmap_size;
    logic         start_signal;
    logic         busy;
    logic         overflow;

    int tests = 0;
    int fails = 0;
    int cyc = 0;
    int last_strobe = 0;
    logic [127:0] exp_bm[$];
    int           exp_size[$];

    always #5 clock = ~clock;

    bitmap_stream_loader #(
        .IN_SIZE_WIDTH        (32),
        .BITMAP_MEM_WIDTH     (128),
        .WORD_WIDTH           (32),
        .MAX_BITMAP_MEM_DEPTH (MAXD)
    ) dut (
        .clock           (clock),
        .reset_n         (reset_n),
        .s_data          (s_data),
        .s_valid         (s_valid),
        .s_last          (s_last),
        .s_last_bits     (s_last_bits),
        .s_ready         (s_ready),
        .ctrl_ready      (ctrl_ready),
        .done_signal     (done_signal),
        .init            (init),
        .in_bitmap       (in_bitmap),
        .in_bitmap_valid (in_bitmap_valid),
        .in_bitmap_size  (in_bitmap_size),
        .start_signal    (start_signal),
        .busy            (busy),
        .overflow        (overflow)
    );

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name);
        tests++;
        fails++;
        $display("FAIL %s: bound expired or unexpected event", name);
    endtask

    task automatic check_reset_outputs();
        check("rst_ctl", {s_ready, init, in_bitmap_valid, start_signal, busy, overflow}, 0);
        check("rst_bitmap", in_bitmap, 0);
        check("rst_size", in_bitmap_size, 0);
    endtask

    always @(posedge clock) cyc++;

    // Monitor: every strobe and start pulse must match the next queued expectation.
    always @(negedge clock) begin
        if (reset_n) begin
            if (in_bitmap_valid) begin
                last_strobe = cyc;
                if (exp_bm.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL stray_strobe: got %0h with no strobe expected", in_bitmap);
                end else begin
                    check("bitmap", in_bitmap, exp_bm.pop_front());
                end
            end
            if (start_signal) begin
                if (exp_size.size() == 0) begin
                    fail_now("stray_start");
                end else begin
                    check("size_at_start", in_bitmap_size, exp_size.pop_front());
                    check("start_gap", cyc - last_strobe, 2);
                end
            end
        end
    end

    task automatic send_frame(input int n, input int lb, input bit seq, input int abort_after,
                              input int hold, input bit stray);
        logic [31:0]  w[$];
        logic [127:0] bm;
        int  kept;
        int  eff;
        int  exp_sz;
        int  guard;
        bit  ovf;
        bit  init_seen;
        for (int i = 0; i < n; i++) w.push_back(seq ? 32'(i) : $urandom);
        eff    = (lb == 0 || lb > 32) ? 32 : lb;
        ovf    = (n > MAXD * 4);
        kept   = ovf ? MAXD * 4 : n;
        exp_sz = 32 * (n - 1) + eff;
        if (abort_after == 0) begin
            for (int b = 0; b * 4 < kept; b++) begin
                bm = '0;
                for (int k = 0; k < 4; k++)
                    if (b * 4 + k < kept) bm[32*k +: 32] = w[b*4+k];
                exp_bm.push_back(bm);
            end
            if (!ovf) exp_size.push_back(exp_sz);
        end

        s_valid = 1'b1;
        s_data = w[0];
        s_last = (n == 1);
        s_last_bits = 6'(lb);
        if (hold > 0) begin
            ctrl_ready = 1'b0;
            for (int c = 0; c < hold; c++) begin
                @(posedge clock); #1;
                check("held_ready", s_ready, 0);
                check("held_init", init, 0);
            end
            ctrl_ready = 1'b1;
            @(posedge clock); #1;
            check("init_pulse", init, 1);
            check("init_ready", s_ready, 0);
            @(posedge clock); #1;
            check("fill_ready", s_ready, 1);
            check("init_drop", init, 0);
        end else begin
            ctrl_ready = 1'b1;
            init_seen = 1'b0;
            guard = 0;
            while (!s_ready && guard < 20) begin
                @(posedge clock); #1;
                if (init) init_seen = 1'b1;
                guard++;
            end
            if (guard >= 20) fail_now("ready_wait");
            check("frame_init", init_seen, 1);
        end

        for (int i = 0; i < n; i++) begin
            if (stray && $urandom_range(0, 3) == 0) begin
                s_valid = 1'b0;
                done_signal = 1'b1;
                @(posedge clock); #1;
                done_signal = 1'b0;
                check("stray_done_busy", busy, 1);
                check("stray_done_ready", s_ready, 1);
            end
            s_valid = 1'b1;
            s_data = w[i];
            s_last = (i == n - 1);
            @(posedge clock); #1;
            if (abort_after == i + 1) begin
                reset_n = 1'b0;
                s_valid = 1'b0;
                s_last = 1'b0;
                #1;
                check_reset_outputs();
                @(negedge clock);
                @(negedge clock);
                reset_n = 1'b1;
                return;
            end
        end
        s_valid = 1'b0;
        s_last = 1'b0;

        if (ovf) begin
            check("ovf_flag", overflow, 1);
            check("ovf_idle", busy, 0);
            repeat (3) @(posedge clock);
            #1;
            check("ovf_strobes_left", exp_bm.size(), 0);
            check("ovf_ready", s_ready, 0);
        end else begin
            check("no_ovf", overflow, 0);
            check("gap_busy", busy, 1);
            guard = 0;
            while ((exp_size.size() != 0 || exp_bm.size() != 0) && guard < 10) begin
                @(posedge clock); #1;
                guard++;
            end
            if (guard >= 10) fail_now("start_wait");
            check("wait_busy", busy, 1);
            check("size_hold", in_bitmap_size, exp_sz);
            repeat ($urandom_range(0, 3)) @(posedge clock);
            #1;
            done_signal = 1'b1;
            @(posedge clock); #1;
            done_signal = 1'b0;
            check("done_idle", busy, 0);
            check("size_after_done", in_bitmap_size, exp_sz);
        end
    endtask

    initial begin
        repeat (3) @(negedge clock);
        check_reset_outputs();
        reset_n = 1'b1;
        @(negedge clock);

        send_frame(8, 32, 1'b1, 0, 0, 1'b1);
        send_frame(5, 7, 1'b0, 0, 0, 1'b0);
        send_frame(9, 32, 1'b1, 0, 0, 1'b0);
        send_frame(1, 0, 1'b0, 0, 0, 1'b0);
        send_frame(4, 3, 1'b0, 0, 4, 1'b0);
        send_frame(6, 32, 1'b0, 2, 0, 1'b0);
        send_frame(3, 40, 1'b0, 0, 0, 1'b1);
        repeat (25) begin
            send_frame(int'($urandom_range(1, 12)), int'($urandom_range(0, 63)), 1'b0, 0, 0,
                       1'($urandom_range(0, 1)));
        end
        check("final_bm_queue", exp_bm.size(), 0);
        check("final_size_queue", exp_size.size(), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #1000000;
        fail_now("global_timeout");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
